// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register write scoreboard.
// Per-register pending-write counters are driven by a small operation code.
package reg_scoreboard_pkg;

  localparam int SCB_NUM_REGS = 32;
  localparam int SCB_CNT_W    = 2;
  localparam int SCB_ADDR_W   = 5;

  localparam logic [SCB_ADDR_W-1:0] SCB_REG0 = 5'd0;

  typedef enum logic [1:0] {
    SCB_HOLD = 2'd0,
    SCB_INC  = 2'd1,
    SCB_DEC  = 2'd2,
    SCB_CLR  = 2'd3
  } scb_op_e;

endpackage

// File: rtl/scb_entry.sv
// One pending-write counter: saturating inc/dec with a sticky error flag.
// Overflow and underflow hold the count and latch err.
module scb_entry
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = SCB_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  scb_op_e          op,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      unique case (op)
        SCB_CLR: cnt <= '0;
        SCB_INC: begin
          if (cnt == CNT_MAX) err <= 1'b1;
          else                cnt <= cnt + CNT_W'(1);
        end
        SCB_DEC: begin
          if (cnt == '0) err <= 1'b1;
          else           cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign nonzero = |cnt;

endmodule

// File: rtl/reg_scoreboard.sv
// Tracks in-flight register writes between ID issue and WB retire and
// raises a read-after-write stall to ID while a source has a pending writer.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS      = SCB_NUM_REGS,
  parameter int CNT_W         = SCB_CNT_W,
  parameter int RETIRE_BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic [SCB_ADDR_W-1:0] issue_waddr,
  input  logic                  rs_used,
  input  logic [SCB_ADDR_W-1:0] rs_addr,
  input  logic                  rt_used,
  input  logic [SCB_ADDR_W-1:0] rt_addr,
  input  logic                  retire_valid,
  input  logic                  retire_we,
  input  logic [SCB_ADDR_W-1:0] retire_waddr,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  err
);

  logic                  issue_evt;
  logic                  retire_evt;
  logic [NUM_REGS-1:1]   issue_hit;
  logic [NUM_REGS-1:1]   retire_hit;
  logic [NUM_REGS-1:1]   err_vec;
  scb_op_e               entry_op [NUM_REGS-1:1];
  logic [CNT_W-1:0]      cnt      [NUM_REGS];
  logic                  hazard_rs;
  logic                  hazard_rt;

  // Flush wins; a simultaneous issue and retire on one register cancel out.
  function automatic scb_op_e op_sel(input logic clr, input logic inc, input logic dec);
    if (clr)        return SCB_CLR;
    if (inc && !dec) return SCB_INC;
    if (dec && !inc) return SCB_DEC;
    return SCB_HOLD;
  endfunction

  // A last pending writer retiring this cycle is written through the regfile.
  function automatic logic hazard(input logic                  used,
                                  input logic [SCB_ADDR_W-1:0] addr,
                                  input logic [CNT_W-1:0]      c,
                                  input logic                  r_evt,
                                  input logic [SCB_ADDR_W-1:0] r_addr);
    logic h;
    h = used && (addr != SCB_REG0) && (c != '0);
    if ((RETIRE_BYPASS != 0) && r_evt && (r_addr == addr) && (c == CNT_W'(1)))
      h = 1'b0;
    return h;
  endfunction

  assign issue_evt  = issue_valid  & issue_we  & (issue_waddr  != SCB_REG0);
  assign retire_evt = retire_valid & retire_we & (retire_waddr != SCB_REG0);

  always_comb begin
    issue_hit  = '0;
    retire_hit = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      issue_hit[i]  = issue_evt  && (issue_waddr  == SCB_ADDR_W'(i));
      retire_hit[i] = retire_evt && (retire_waddr == SCB_ADDR_W'(i));
      entry_op[i]   = op_sel(flush, issue_hit[i], retire_hit[i]);
    end
  end

  assign cnt[0]      = '0;
  assign busy_vec[0] = 1'b0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
    scb_entry #(
      .CNT_W (CNT_W)
    ) u_entry (
      .clk     (clk),
      .reset   (reset),
      .op      (entry_op[i]),
      .cnt     (cnt[i]),
      .nonzero (busy_vec[i]),
      .err     (err_vec[i])
    );
  end

  assign hazard_rs = hazard(rs_used, rs_addr, cnt[rs_addr], retire_evt, retire_waddr);
  assign hazard_rt = hazard(rt_used, rt_addr, cnt[rt_addr], retire_evt, retire_waddr);
  assign stall     = hazard_rs | hazard_rt;
  assign err       = |err_vec;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed table-driven bench for reg_scoreboard: each row drives one cycle
// and checks stall plus the registered state seen before that cycle's edge.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        issue_valid, issue_we;
  logic [4:0]  issue_waddr;
  logic        rs_used, rt_used;
  logic [4:0]  rs_addr, rt_addr;
  logic        retire_valid, retire_we;
  logic [4:0]  retire_waddr;
  logic        stall, err;
  logic [31:0] busy_vec;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        fl;
    logic        iv, iwe;
    logic [4:0]  ia;
    logic        rsu;
    logic [4:0]  rsa;
    logic        rtu;
    logic [4:0]  rta;
    logic        rv, rwe;
    logic [4:0]  ra;
    logic        st;
    logic [31:0] busy;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  reg_scoreboard #(.NUM_REGS(32), .CNT_W(2), .RETIRE_BYPASS(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_we     (issue_we),
    .issue_waddr  (issue_waddr),
    .rs_used      (rs_used),
    .rs_addr      (rs_addr),
    .rt_used      (rt_used),
    .rt_addr      (rt_addr),
    .retire_valid (retire_valid),
    .retire_we    (retire_we),
    .retire_waddr (retire_waddr),
    .stall        (stall),
    .busy_vec     (busy_vec),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic add(input logic fl, input logic iv, input logic iwe, input logic [4:0] ia,
                     input logic rsu, input logic [4:0] rsa, input logic rtu, input logic [4:0] rta,
                     input logic rv, input logic rwe, input logic [4:0] ra,
                     input logic st, input logic [31:0] busy, input logic er);
    vec_t v;
    v.fl = fl; v.iv = iv; v.iwe = iwe; v.ia = ia;
    v.rsu = rsu; v.rsa = rsa; v.rtu = rtu; v.rta = rta;
    v.rv = rv; v.rwe = rwe; v.ra = ra;
    v.st = st; v.busy = busy; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    flush = v.fl; issue_valid = v.iv; issue_we = v.iwe; issue_waddr = v.ia;
    rs_used = v.rsu; rs_addr = v.rsa; rt_used = v.rtu; rt_addr = v.rta;
    retire_valid = v.rv; retire_we = v.rwe; retire_waddr = v.ra;
  endtask

  task automatic idle();
    flush = 0; issue_valid = 0; issue_we = 0; issue_waddr = 0;
    rs_used = 0; rs_addr = 0; rt_used = 0; rt_addr = 0;
    retire_valid = 0; retire_we = 0; retire_waddr = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Reset then idle.
    for (int i = 0; i < 10; i++) add(0, 0,0,0, 0,0, 0,0, 0,0,0, 0, 32'h0, 0);
    // r5: issue, dependent rs stalls until the retire cycle (bypassed).
    add(0, 1,1,5, 0,0, 0,0, 0,0,0, 0, 32'h0,  0);
    add(0, 0,0,0, 1,5, 0,0, 0,0,0, 1, 32'h20, 0);
    add(0, 0,0,0, 1,5, 0,0, 0,1,5, 1, 32'h20, 0);
    add(0, 0,0,0, 1,5, 0,0, 1,1,5, 0, 32'h20, 0);
    add(0, 0,0,0, 1,5, 0,0, 0,0,0, 0, 32'h0,  0);
    // r7: three issues, one retire, then overflow; retires prove count held at 3.
    add(0, 1,1,7, 0,0, 0,0, 0,0,0, 0, 32'h0,  0);
    add(0, 1,1,7, 0,0, 0,0, 0,0,0, 0, 32'h80, 0);
    add(0, 1,1,7, 0,0, 0,0, 0,0,0, 0, 32'h80, 0);
    add(0, 0,0,0, 0,0, 1,7, 1,1,7, 1, 32'h80, 0);
    add(0, 0,0,0, 0,0, 1,7, 1,0,7, 1, 32'h80, 0);
    add(0, 1,1,7, 0,0, 0,0, 0,0,0, 0, 32'h80, 0);
    add(0, 1,1,7, 0,0, 0,0, 0,0,0, 0, 32'h80, 0);
    add(0, 0,0,0, 0,0, 0,0, 0,0,0, 0, 32'h80, 1);
    add(0, 0,0,0, 0,0, 0,0, 1,1,7, 0, 32'h80, 1);
    add(0, 0,0,0, 0,0, 0,0, 1,1,7, 0, 32'h80, 1);
    add(0, 0,0,0, 0,0, 1,7, 1,1,7, 0, 32'h80, 1);
    add(0, 0,0,0, 1,7, 0,0, 0,0,0, 0, 32'h0,  1);
    // r3=2, r4=1, then flush alongside an issue to r3; err survives.
    add(0, 1,1,3, 0,0, 0,0, 0,0,0, 0, 32'h0,  1);
    add(0, 1,1,3, 0,0, 0,0, 0,0,0, 0, 32'h8,  1);
    add(0, 1,1,4, 1,3, 0,0, 0,0,0, 1, 32'h8,  1);
    add(1, 1,1,3, 0,0, 0,0, 0,0,0, 0, 32'h18, 1);
    add(0, 0,0,0, 1,3, 1,4, 0,0,0, 0, 32'h0,  1);
    for (int i = 0; i < 3; i++) begin
      vecs[i].st = vecs[i].st;
    end

    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("row%0d stall", i), {31'b0, stall}, {31'b0, vecs[i].st});
      chk($sformatf("row%0d busy_vec", i), busy_vec, vecs[i].busy);
      chk($sformatf("row%0d err", i), {31'b0, err}, {31'b0, vecs[i].er});
    end

    // Fresh reset, then r0 traffic and same-cycle issue/retire on r9.
    @(negedge clk); idle(); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    issue_valid = 1; issue_we = 1; issue_waddr = 0;
    rs_used = 1; rs_addr = 0; rt_used = 1; rt_addr = 0;
    retire_valid = 1; retire_we = 1; retire_waddr = 0;
    #1 chk("r0 stall", {31'b0, stall}, 32'h0);
    @(negedge clk); idle(); rs_used = 1; rt_used = 1;
    #1 chk("r0 busy_vec", busy_vec, 32'h0);
    chk("r0 err", {31'b0, err}, 32'h0);
    chk("r0 stall idle", {31'b0, stall}, 32'h0);

    idle(); issue_valid = 1; issue_we = 1; issue_waddr = 9;
    @(negedge clk); retire_valid = 1; retire_we = 1; retire_waddr = 9;
    #1 chk("r9 busy before", busy_vec, 32'h200);
    @(negedge clk); idle(); issue_valid = 1; issue_we = 0; issue_waddr = 9;
    #1 chk("r9 busy after same-cycle", busy_vec, 32'h200);
    @(negedge clk); idle(); rs_used = 1; rs_addr = 9;
    #1 chk("r9 stall count1", {31'b0, stall}, 32'h1);
    @(negedge clk); retire_valid = 1; retire_we = 1; retire_waddr = 9;
    #1 chk("r9 bypass", {31'b0, stall}, 32'h0);
    @(negedge clk); idle();
    #1 chk("r9 drained", busy_vec, 32'h0);

    // Underflow sets err without disturbing the counter.
    retire_valid = 1; retire_we = 1; retire_waddr = 2;
    @(negedge clk); idle(); rs_used = 1; rs_addr = 2;
    #1 chk("underflow err", {31'b0, err}, 32'h1);
    chk("underflow busy", busy_vec, 32'h0);
    chk("underflow stall", {31'b0, stall}, 32'h0);

    // Reset mid-operation with issue and retire active.
    idle(); issue_valid = 1; issue_we = 1; issue_waddr = 6;
    @(negedge clk);
    #1 chk("pre-reset busy", busy_vec, 32'h40);
    reset = 1; issue_waddr = 8; retire_valid = 1; retire_we = 1; retire_waddr = 6;
    @(negedge clk); reset = 0; idle(); rs_used = 1; rs_addr = 8; rt_used = 1; rt_addr = 6;
    #1 chk("post-reset busy", busy_vec, 32'h0);
    chk("post-reset err", {31'b0, err}, 32'h0);
    chk("post-reset stall", {31'b0, stall}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
